stream_demux_n: RTL and testbench

Registered 1-to-NUM_OUT packet demultiplexer with valid/ready handshakes on the input and on every output. It is the parametrised successor of the team's combinational 1-to-4 demux. A channel is chosen per packet, either by an explicit select or by round-robin, and held until the packet's last beat is accepted. Each output has a one-beat register slot, so data reaches an output one cycle after it is accepted. Sits between a single producer and NUM_OUT consumer lanes.

---
 rtl/stream_demux_n.sv | 90 +++++++++
 tb/tb_stream_demux_n.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-NUM_OUT packet demux with per-packet channel lock,
// round-robin or explicit select, and a saturating counter of dropped out-of-range packets.
module stream_demux_n #(
  parameter int DATA_W  = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      rr_mode,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_last,
  output logic                      busy,
  output logic [SEL_W-1:0]          cur_chan,
  output logic [CNT_W-1:0]          drop_cnt
);
  typedef enum logic [1:0] {IDLE, LOCKED, DROP} state_t;
  state_t                    state_q, state_d;
  logic [SEL_W-1:0]          rr_q, rr_d, chan_q, chan_d, target;
  logic [CNT_W-1:0]          drop_q, drop_d;
  logic [NUM_OUT-1:0]        valid_q, valid_d, last_q, load;
  logic [NUM_OUT*DATA_W-1:0] data_q;
  logic                      in_range, slot_free, dropping, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      chan_q  <= '0;
      drop_q  <= '0;
      valid_q <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      chan_q  <= chan_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      for (int k = 0; k < NUM_OUT; k++)
        if (load[k]) begin
          data_q[k*DATA_W +: DATA_W] <= in_data;
          last_q[k]                  <= in_last;
        end
    end
  end

  // The open packet keeps its channel; only a first beat looks at in_sel/rr_mode.
  always_comb begin
    target    = state_q == LOCKED ? chan_q : (rr_mode ? rr_q : in_sel);
    in_range  = {1'b0, target} < (SEL_W+1)'(NUM_OUT);
    dropping  = state_q == DROP || (state_q == IDLE && !in_range);
    accept    = in_valid && in_ready;
    slot_free = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (target == SEL_W'(k)) slot_free = !valid_q[k] || out_ready[k];
      load[k] = accept && !dropping && target == SEL_W'(k);
    end
    valid_d = load | (valid_q & ~out_ready);
    state_d = state_q;
    chan_d  = chan_q;
    rr_d    = rr_q;
    drop_d  = drop_q;
    if (accept) begin
      if (state_q == IDLE && !in_last) state_d = in_range ? LOCKED : DROP;
      if (state_q != IDLE && in_last) state_d = IDLE;
      chan_d = (in_last || dropping) ? '0 : target;
      if (in_last && !dropping) rr_d = rr_q == SEL_W'(NUM_OUT-1) ? '0 : rr_q + SEL_W'(1);
      if (in_last && dropping && drop_q != '1) drop_d = drop_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready  = dropping || slot_free;
    busy      = state_q != IDLE;
    cur_chan  = chan_q;
    drop_cnt  = drop_q;
    out_valid = valid_q;
    out_data  = data_q;
    out_last  = last_q;
  end
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: directed checks of routing, locking, backpressure, round-robin,
// dropping and asynchronous reset on a 4-channel and a 3-channel instance.
module tb_stream_demux_n;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, rr_mode;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;
  logic        in_ready, busy, in_ready3, busy3;
  logic [3:0]  out_valid, out_last;
  logic [31:0] out_data;
  logic [1:0]  cur_chan, cur_chan3, drop_cnt3;
  logic [7:0]  drop_cnt;
  logic [2:0]  out_valid3, out_last3;
  logic [23:0] out_data3;
  int vec = 0, err = 0;

  always #5 clk = ~clk;

  stream_demux_n dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel), .rr_mode(rr_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .cur_chan(cur_chan), .drop_cnt(drop_cnt)
  );

  stream_demux_n #(.NUM_OUT(3), .CNT_W(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .in_last(in_last), .in_sel(in_sel), .rr_mode(rr_mode), .out_valid(out_valid3),
    .out_ready(out_ready[2:0]), .out_data(out_data3), .out_last(out_last3), .busy(busy3),
    .cur_chan(cur_chan3), .drop_cnt(drop_cnt3)
  );

  function automatic logic [7:0] lane(input logic [31:0] d, input int k);
    return d[k*8 +: 8];
  endfunction

  task automatic drive(input logic [7:0] d, input logic [1:0] s, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    in_last  = l;
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; rr_mode = 1'b0;
    in_data = '0; in_sel = '0; out_ready = 4'b1111;
    #1;
    vec++; if (out_valid !== 4'b0) begin err++; $display("FAIL reset_valid got %h exp 0", out_valid); end
    vec++; if (out_data !== 32'b0) begin err++; $display("FAIL reset_data got %h exp 0", out_data); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got %b exp 0", busy); end
    vec++; if (cur_chan !== 2'd0) begin err++; $display("FAIL reset_chan got %0d exp 0", cur_chan); end
    vec++; if (drop_cnt !== 8'd0) begin err++; $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_ready got %b exp 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    for (int k = 0; k < 4; k++) begin
      drive(8'(8'hA0 + k), 2'(k), 1'b1);
      vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL single_ready%0d got %b exp 1", k, in_ready); end
      @(posedge clk); #1;
      vec++; if (out_valid !== 4'(1 << k)) begin err++; $display("FAIL single_valid%0d got %b exp %b", k, out_valid, 4'(1 << k)); end
      vec++; if (lane(out_data, k) !== 8'(8'hA0 + k)) begin err++; $display("FAIL single_data%0d got %h exp %h", k, lane(out_data, k), 8'(8'hA0 + k)); end
      vec++; if (out_last[k] !== 1'b1) begin err++; $display("FAIL single_last%0d got %b exp 1", k, out_last[k]); end
    end
    go_idle();
    @(posedge clk); #1;
    vec++; if (out_valid !== 4'b0) begin err++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_lock();
    logic [7:0] d[3] = '{8'h11, 8'h22, 8'h33};
    logic [1:0] s[3] = '{2'd2, 2'd1, 2'd1};
    for (int i = 0; i < 3; i++) begin
      drive(d[i], s[i], i == 2);
      vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL lock_ready%0d got %b exp 1", i, in_ready); end
      @(posedge clk); #1;
      vec++; if (out_valid !== 4'b0100) begin err++; $display("FAIL lock_valid%0d got %b exp 0100", i, out_valid); end
      vec++; if (lane(out_data, 2) !== d[i]) begin err++; $display("FAIL lock_data%0d got %h exp %h", i, lane(out_data, 2), d[i]); end
      vec++; if (busy !== (i != 2)) begin err++; $display("FAIL lock_busy%0d got %b exp %b", i, busy, i != 2); end
      vec++; if (cur_chan !== (i == 2 ? 2'd0 : 2'd2)) begin err++; $display("FAIL lock_chan%0d got %0d exp %0d", i, cur_chan, i == 2 ? 0 : 2); end
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 4'b1101;
    drive(8'h55, 2'd1, 1'b0);
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL bp_ready0 got %b exp 1", in_ready); end
    @(posedge clk); #1;
    vec++; if (out_valid !== 4'b0010) begin err++; $display("FAIL bp_valid0 got %b exp 0010", out_valid); end
    vec++; if (lane(out_data, 1) !== 8'h55) begin err++; $display("FAIL bp_data0 got %h exp 55", lane(out_data, 1)); end
    drive(8'h66, 2'd1, 1'b1);
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL bp_stall0 got %b exp 0", in_ready); end
    @(posedge clk); #1;
    vec++; if (out_valid !== 4'b0010) begin err++; $display("FAIL bp_hold_valid got %b exp 0010", out_valid); end
    vec++; if (lane(out_data, 1) !== 8'h55) begin err++; $display("FAIL bp_hold_data got %h exp 55", lane(out_data, 1)); end
    vec++; if (out_last[1] !== 1'b0) begin err++; $display("FAIL bp_hold_last got %b exp 0", out_last[1]); end
    @(negedge clk);
    vec++; if (in_ready !== 1'b0) begin err++; $display("FAIL bp_stall1 got %b exp 0", in_ready); end
    out_ready = 4'b1111;
    #1;
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL bp_release got %b exp 1", in_ready); end
    @(posedge clk); #1;
    vec++; if (out_valid !== 4'b0010) begin err++; $display("FAIL bp_valid1 got %b exp 0010", out_valid); end
    vec++; if (lane(out_data, 1) !== 8'h66) begin err++; $display("FAIL bp_data1 got %h exp 66", lane(out_data, 1)); end
    vec++; if (out_last[1] !== 1'b1) begin err++; $display("FAIL bp_last1 got %b exp 1", out_last[1]); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL bp_busy got %b exp 0", busy); end
    go_idle();
    @(posedge clk); #1;
    vec++; if (out_valid !== 4'b0) begin err++; $display("FAIL bp_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    rr_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(8'(8'h30 + i), 2'd3, 1'b1);
      vec++; if (in_ready !== 1'b1 || in_ready3 !== 1'b1) begin err++; $display("FAIL rr_ready%0d got %b%b exp 11", i, in_ready, in_ready3); end
      @(posedge clk); #1;
      vec++; if (out_valid !== 4'(1 << (i % 4))) begin err++; $display("FAIL rr4_valid%0d got %b exp %b", i, out_valid, 4'(1 << (i % 4))); end
      vec++; if (lane(out_data, i % 4) !== 8'(8'h30 + i)) begin err++; $display("FAIL rr4_data%0d got %h exp %h", i, lane(out_data, i % 4), 8'(8'h30 + i)); end
      vec++; if (out_valid3 !== 3'(1 << (i % 3))) begin err++; $display("FAIL rr3_valid%0d got %b exp %b", i, out_valid3, 3'(1 << (i % 3))); end
      vec++; if (lane({8'h0, out_data3}, i % 3) !== 8'(8'h30 + i)) begin err++; $display("FAIL rr3_data%0d got %h exp %h", i, lane({8'h0, out_data3}, i % 3), 8'(8'h30 + i)); end
    end
    go_idle();
    rr_mode = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    drive(8'h77, 2'd3, 1'b0);
    vec++; if (in_ready3 !== 1'b1) begin err++; $display("FAIL drop_ready0 got %b exp 1", in_ready3); end
    @(posedge clk); #1;
    vec++; if (out_valid3 !== 3'b0) begin err++; $display("FAIL drop_valid0 got %b exp 0", out_valid3); end
    vec++; if (busy3 !== 1'b1) begin err++; $display("FAIL drop_busy0 got %b exp 1", busy3); end
    vec++; if (drop_cnt3 !== 2'd0) begin err++; $display("FAIL drop_cnt0 got %0d exp 0", drop_cnt3); end
    drive(8'h78, 2'd0, 1'b1);
    vec++; if (in_ready3 !== 1'b1) begin err++; $display("FAIL drop_ready1 got %b exp 1", in_ready3); end
    @(posedge clk); #1;
    vec++; if (out_valid3 !== 3'b0) begin err++; $display("FAIL drop_valid1 got %b exp 0", out_valid3); end
    vec++; if (busy3 !== 1'b0) begin err++; $display("FAIL drop_busy1 got %b exp 0", busy3); end
    vec++; if (drop_cnt3 !== 2'd1) begin err++; $display("FAIL drop_cnt1 got %0d exp 1", drop_cnt3); end
    for (int p = 2; p <= 5; p++) begin
      drive(8'h80, 2'd3, 1'b1);
      @(posedge clk); #1;
      vec++; if (drop_cnt3 !== 2'(p > 3 ? 3 : p)) begin err++; $display("FAIL drop_sat%0d got %0d exp %0d", p, drop_cnt3, p > 3 ? 3 : p); end
      vec++; if (out_valid3 !== 3'b0) begin err++; $display("FAIL drop_quiet%0d got %b exp 0", p, out_valid3); end
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 4'b0000;
    drive(8'h9A, 2'd2, 1'b0);
    @(posedge clk); #1;
    vec++; if (out_valid !== 4'b0100 || busy !== 1'b1 || cur_chan !== 2'd2) begin err++; $display("FAIL mid_locked got %b/%b/%0d exp 0100/1/2", out_valid, busy, cur_chan); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    vec++; if (out_valid !== 4'b0) begin err++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    vec++; if (out_data !== 32'b0 || out_last !== 4'b0) begin err++; $display("FAIL mid_data got %h/%b exp 0/0", out_data, out_last); end
    vec++; if (busy !== 1'b0 || cur_chan !== 2'd0) begin err++; $display("FAIL mid_state got %b/%0d exp 0/0", busy, cur_chan); end
    vec++; if (drop_cnt3 !== 2'd0) begin err++; $display("FAIL mid_drop got %0d exp 0", drop_cnt3); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    drive(8'h5C, 2'd3, 1'b1);
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL mid_ready got %b exp 1", in_ready); end
    @(posedge clk); #1;
    vec++; if (out_valid !== 4'b1000) begin err++; $display("FAIL mid_route got %b exp 1000", out_valid); end
    vec++; if (lane(out_data, 3) !== 8'h5C) begin err++; $display("FAIL mid_data3 got %h exp 5c", lane(out_data, 3)); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL mid_busy got %b exp 0", busy); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_lock();
    test_backpressure();
    test_round_robin();
    test_drop();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
